// File: rtl/pc_fetch_gen_if.sv
// Fetch-generator bus: redirect/stall/handshake inputs and the fetch
// request, architectural PC and fault outputs.
interface pc_fetch_gen_if;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        stall;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] pc_arch;
   logic [31:0] link_pc;
   logic        fault;
   logic [31:0] fault_addr;

   // The fetch generator drives the request and PC outputs.
   modport master (
      input  redirect_valid, redirect_target, stall, fetch_ready,
      output fetch_valid, fetch_pc, pc_arch, link_pc, fault, fault_addr
   );

   // Resolution logic / IMEM side.
   modport slave (
      output redirect_valid, redirect_target, stall, fetch_ready,
      input  fetch_valid, fetch_pc, pc_arch, link_pc, fault, fault_addr
   );
endinterface

// File: rtl/pc_fetch_gen.sv
// Fetch-address generator. Holds the program counter in physical IMEM
// space, converts architectural redirect targets to physical by adding
// PC_BASE, and raises a sticky fault on misaligned or out-of-range
// targets or on sequential fall-off past the end of IMEM.
module pc_fetch_gen #(
   parameter logic [31:0] PC_BASE    = 32'h0100_0000,
   parameter logic [31:0] IMEM_BYTES = 32'h0000_1000
) (
   input  logic           clk,
   input  logic           rst,
   pc_fetch_gen_if.master bus
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pc_arch_q, pc_arch_d;
   logic [31:0] link_pc_q;
   logic [31:0] fault_addr_q, fault_addr_d;
   logic        fetch_valid_q;
   logic        fault_q;

   logic        tgt_bad;
   logic [31:0] seq_arch;

   // Target check is on the architectural address, before the base is added,
   // so a huge target cannot wrap into a legal physical address.
   always_comb begin
      tgt_bad  = (bus.redirect_target[1:0] != 2'b00) ||
                 (bus.redirect_target >= IMEM_BYTES);
      seq_arch = pc_arch_q + 32'd4;
   end

   // Next-state and next-PC selection: redirect > stall > accepted advance.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      pc_arch_d    = pc_arch_q;
      fault_addr_d = fault_addr_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.redirect_valid) begin
               if (tgt_bad) begin
                  state_d      = ST_FAULT;
                  fault_addr_d = bus.redirect_target;
               end else begin
                  fetch_pc_d = PC_BASE + bus.redirect_target;
                  pc_arch_d  = bus.redirect_target;
               end
            end else if (bus.stall) begin
               state_d = ST_RUN;
            end else if (fetch_valid_q && bus.fetch_ready) begin
               // Falling off the end faults instead of wrapping; the PC
               // stays on the last legal word.
               if (seq_arch == IMEM_BYTES) begin
                  state_d      = ST_FAULT;
                  fault_addr_d = IMEM_BYTES;
               end else begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  pc_arch_d  = seq_arch;
               end
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State and output registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_BOOT;
         fetch_pc_q    <= PC_BASE;
         pc_arch_q     <= 32'd0;
         link_pc_q     <= 32'd4;
         fault_addr_q  <= 32'd0;
         fetch_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         pc_arch_q     <= pc_arch_d;
         link_pc_q     <= pc_arch_d + 32'd4;
         fault_addr_q  <= fault_addr_d;
         fetch_valid_q <= (state_d == ST_RUN);
         fault_q       <= (state_d == ST_FAULT);
      end
   end

   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_pc    = fetch_pc_q;
   assign bus.pc_arch     = pc_arch_q;
   assign bus.link_pc     = link_pc_q;
   assign bus.fault       = fault_q;
   assign bus.fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Testbench for pc_fetch_gen: directed scenarios followed by random
// redirect/stall/backpressure/reset traffic against a behavioural model.
module tb_pc_fetch_gen;

   localparam logic [31:0] BASE = 32'h0100_0000;
   localparam logic [31:0] IMEM = 32'h0000_1000;

   localparam int M_BOOT  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FAULT = 2;

   logic clk;
   logic rst;

   pc_fetch_gen_if bus ();

   pc_fetch_gen #(
      .PC_BASE    (BASE),
      .IMEM_BYTES (IMEM)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: mode plus the architectural PC; everything else
   // visible is derived from these.
   int          m_mode  = M_BOOT;
   logic [31:0] m_arch  = 32'd0;
   logic [31:0] m_faddr = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic rv, input logic [31:0] tgt,
                        input logic st, input logic rdy);
      if (r) begin
         m_mode  = M_BOOT;
         m_arch  = 32'd0;
         m_faddr = 32'd0;
      end else if (m_mode == M_BOOT) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (rv) begin
            if ((tgt % 4) != 0 || tgt >= IMEM) begin
               m_mode  = M_FAULT;
               m_faddr = tgt;
            end else begin
               m_arch = tgt;
            end
         end else if (!st && rdy) begin
            if (m_arch + 4 == IMEM) begin
               m_mode  = M_FAULT;
               m_faddr = IMEM;
            end else begin
               m_arch = m_arch + 4;
            end
         end
      end
   endtask

   // One clock: drive at negedge, model the edge, compare 1 time unit later.
   task automatic step(input logic r, input logic rv, input logic [31:0] tgt,
                       input logic st, input logic rdy);
      @(negedge clk);
      rst                 = r;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
      bus.stall           = st;
      bus.fetch_ready     = rdy;
      @(posedge clk);
      model(r, rv, tgt, st, rdy);
      #1;
      chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, (m_mode == M_RUN)});
      chk("fetch_pc",    bus.fetch_pc,             BASE + m_arch);
      chk("pc_arch",     bus.pc_arch,              m_arch);
      chk("link_pc",     bus.link_pc,              m_arch + 32'd4);
      chk("fault",       {31'd0, bus.fault},       {31'd0, (m_mode == M_FAULT)});
      chk("fault_addr",  bus.fault_addr,           m_faddr);
   endtask

   initial begin
      logic [31:0] tgt;
      int          kind;

      rst                 = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 32'd0;
      bus.stall           = 1'b0;
      bus.fetch_ready     = 1'b0;

      // Reset, boot, then sequential fetch.
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("rst_fv",    {31'd0, bus.fetch_valid}, 32'd0);
      chk("rst_pc",    bus.fetch_pc,  32'h0100_0000);
      chk("rst_link",  bus.link_pc,   32'd4);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("seq_pc0",   bus.fetch_pc,  32'h0100_0000);
      chk("seq_fv",    {31'd0, bus.fetch_valid}, 32'd1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("seq_pc4",   bus.fetch_pc,  32'h0100_0004);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("seq_pc8",   bus.fetch_pc,  32'h0100_0008);
      chk("seq_arch8", bus.pc_arch,   32'd8);

      // Stall holds everything even with IMEM ready.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      chk("stall_pc",  bus.fetch_pc,  32'h0100_0008);
      chk("stall_lnk", bus.link_pc,   32'd12);

      // Redirect wins over stall and missing ready.
      step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
      chk("redir_pc",  bus.fetch_pc,  32'h0100_0100);
      chk("redir_arc", bus.pc_arch,   32'h100);
      chk("redir_lnk", bus.link_pc,   32'h104);

      // Misaligned target faults; later redirects are ignored.
      step(1'b0, 1'b1, 32'h102, 1'b0, 1'b1);
      chk("mis_fault", {31'd0, bus.fault}, 32'd1);
      chk("mis_faddr", bus.fault_addr, 32'h102);
      step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
      chk("flt_hold",  bus.fetch_pc,  32'h0100_0100);

      // Reset out of FAULT, then boot again.
      step(1'b1, 1'b1, 32'h40, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

      // Fall-off end of IMEM.
      step(1'b0, 1'b1, 32'hFFC, 1'b0, 1'b0);
      chk("end_pc",    bus.fetch_pc,  32'h0100_0FFC);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("end_faddr", bus.fault_addr, 32'h1000);
      chk("end_pchld", bus.fetch_pc,  32'h0100_0FFC);

      // Out-of-range target and a target that would overflow the base add.
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hFF00_0000, 1'b0, 1'b0);

      // Reset mid-RUN while a redirect is presented.
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 32'h80, 1'b0, 1'b1);
      chk("mid_rst",   bus.fetch_pc,  32'h0100_0000);
      step(1'b0, 1'b1, 32'h80, 1'b0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         kind = int'($urandom_range(0, 6));
         case (kind)
            0, 1: tgt = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            2:    tgt = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
            3:    tgt = 32'hFFC - 32'(4 * $urandom_range(0, 3));
            4:    tgt = IMEM + 32'(4 * $urandom_range(0, 3));
            default: tgt = $urandom;
         endcase
         step(($urandom_range(0, 29) == 0),
              ($urandom_range(0, 5) == 0),
              tgt,
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
